three_sum_threshold_monitor: RTL and testbench

Downstream consumer of the three-sample moving-sum stage. It takes the 8-bit `last_three_sum` stream and discards the warm-up outputs that follow reset. It applies hysteresis thresholds to the remaining sums and queues rise/fall alarm events, each stamped with its sample index, into a small FIFO. A downstream reader drains the FIFO over a valid/ready handshake.

---
 rtl/three_sum_threshold_monitor.sv | 161 ++++++++++++++++
 tb/tb_three_sum_threshold_monitor.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/three_sum_threshold_monitor.sv
// Hysteresis alarm monitor for the three-sample moving-sum stream.
// Drops the post-reset warm-up samples, tracks an alarm state with separate
// set/clear levels and queues stamped rise/fall events for a downstream reader.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_WARMUP | discarding the first WARMUP valid samples after reset
// ST_INIT   | next valid sample seeds in_alarm, no event
// ST_NORMAL | not in alarm; sum >= threshold_hi raises a rise event
// ST_ALARM  | in alarm; sum <= threshold_lo raises a fall event
module three_sum_threshold_monitor #(
    parameter int DEPTH  = 4,
    parameter int WARMUP = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  sum_in,
    input  logic        sum_valid,
    input  logic [7:0]  threshold_hi,
    input  logic [7:0]  threshold_lo,
    output logic        event_valid,
    input  logic        event_ready,
    output logic        event_rise,
    output logic [7:0]  event_value,
    output logic [15:0] event_stamp,
    output logic        in_alarm,
    output logic        overflow
);

    localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
    localparam int WW = (WARMUP < 2) ? 1 : $clog2(WARMUP + 1);

    typedef enum logic [1:0] {
        ST_WARMUP,
        ST_INIT,
        ST_NORMAL,
        ST_ALARM
    } state_t;

    // With no warm-up requested, the very first sample seeds the alarm state.
    localparam state_t ST_RESET = (WARMUP == 0) ? ST_INIT : ST_WARMUP;

    state_t        state_q, state_d;
    logic [WW-1:0] warm_q, warm_d;
    logic [15:0]   stamp_q, stamp_d;
    logic          alarm_q, alarm_d;
    logic          ovf_q, ovf_d;
    logic          push_req;
    logic          push_rise;

    logic [24:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          fifo_full;
    logic          pop;
    logic          push;
    logic [24:0]   head;

    assign fifo_full = (cnt_q == (AW + 1)'(DEPTH));
    assign pop       = (cnt_q != '0) && event_ready;
    // A full FIFO still takes the push when the head leaves in the same cycle.
    assign push      = push_req && (!fifo_full || pop);

    // Next-state logic: only valid samples move the FSM and the sample index.
    always_comb begin
        state_d   = state_q;
        warm_d    = warm_q;
        stamp_d   = stamp_q;
        alarm_d   = alarm_q;
        push_req  = 1'b0;
        push_rise = 1'b0;
        if (sum_valid) begin
            stamp_d = stamp_q + 16'd1;
            case (state_q)
                ST_WARMUP: begin
                    warm_d = warm_q - WW'(1);
                    if (warm_q == WW'(1)) begin
                        state_d = ST_INIT;
                    end
                end
                ST_INIT: begin
                    alarm_d = (sum_in >= threshold_hi);
                    state_d = (sum_in >= threshold_hi) ? ST_ALARM : ST_NORMAL;
                end
                ST_NORMAL: begin
                    if (sum_in >= threshold_hi) begin
                        state_d   = ST_ALARM;
                        alarm_d   = 1'b1;
                        push_req  = 1'b1;
                        push_rise = 1'b1;
                    end
                end
                ST_ALARM: begin
                    if (sum_in <= threshold_lo) begin
                        state_d   = ST_NORMAL;
                        alarm_d   = 1'b0;
                        push_req  = 1'b1;
                        push_rise = 1'b0;
                    end
                end
                default: state_d = ST_RESET;
            endcase
        end
    end

    // Sticky overflow: any event that could not be queued.
    assign ovf_d = ovf_q | (push_req & ~push);

    // Occupancy follows the accepted push/pop pair.
    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
            2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_RESET;
            warm_q   <= WW'(WARMUP);
            stamp_q  <= '0;
            alarm_q  <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
            stamp_q <= stamp_d;
            alarm_q <= alarm_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    // Event storage; contents are don't-care until the occupancy covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {push_rise, sum_in, stamp_q};
        end
    end

    assign head        = mem[rd_ptr_q];
    assign event_valid = (cnt_q != '0);
    assign event_rise  = event_valid ? head[24]    : 1'b0;
    assign event_value = event_valid ? head[23:16] : 8'd0;
    assign event_stamp = event_valid ? head[15:0]  : 16'd0;
    assign in_alarm    = alarm_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_three_sum_threshold_monitor.sv
// Scoreboard bench for three_sum_threshold_monitor: a behavioural model of the
// warm-up / hysteresis rules queues expected events as samples are driven,
// and the head of that queue is compared with the DUT's FIFO head each cycle.
module tb_three_sum_threshold_monitor;

    localparam int DEPTH  = 4;
    localparam int WARMUP = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  sum_in = '0;
    logic        sum_valid = 1'b0;
    logic [7:0]  threshold_hi = 8'd100;
    logic [7:0]  threshold_lo = 8'd50;
    logic        event_valid;
    logic        event_ready = 1'b0;
    logic        event_rise;
    logic [7:0]  event_value;
    logic [15:0] event_stamp;
    logic        in_alarm;
    logic        overflow;

    three_sum_threshold_monitor #(.DEPTH(DEPTH), .WARMUP(WARMUP)) dut (
        .clk          (clk),
        .reset        (reset),
        .sum_in       (sum_in),
        .sum_valid    (sum_valid),
        .threshold_hi (threshold_hi),
        .threshold_lo (threshold_lo),
        .event_valid  (event_valid),
        .event_ready  (event_ready),
        .event_rise   (event_rise),
        .event_value  (event_value),
        .event_stamp  (event_stamp),
        .in_alarm     (in_alarm),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    logic [24:0] exp_q[$];
    int          m_warm;
    logic        m_init;
    logic        m_alarm;
    logic        m_ovf;
    logic [15:0] m_stamp;

    // observed pops (DUT showed valid while ready was driven)
    int          dut_pops;
    logic [15:0] last_pop_stamp;
    logic        have_last_pop;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input logic rdy, input logic track_order);
        logic [24:0] h;
        chk("in_alarm", 32'(in_alarm), 32'(m_alarm));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("event_valid", 32'(event_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            h = exp_q[0];
            chk("event_rise", 32'(event_rise), 32'(h[24]));
            chk("event_value", 32'(event_value), 32'(h[23:16]));
            chk("event_stamp", 32'(event_stamp), 32'(h[15:0]));
        end else begin
            chk("idle_rise", 32'(event_rise), 32'd0);
            chk("idle_value", 32'(event_value), 32'd0);
            chk("idle_stamp", 32'(event_stamp), 32'd0);
        end
        if (event_valid && rdy) begin
            dut_pops++;
            if (track_order && have_last_pop) begin
                chk("stamp_order", 32'(event_stamp > last_pop_stamp), 32'd1);
            end
            last_pop_stamp = event_stamp;
            have_last_pop  = 1'b1;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_warm  = WARMUP;
        m_init  = 1'b1;
        m_alarm = 1'b0;
        m_ovf   = 1'b0;
        m_stamp = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b0;
        sum_valid = 1'b0;
        @(posedge clk);
        model_reset();
    endtask

    // One clock: check what the previous edge produced, drive, advance model.
    task automatic step(input logic v, input logic [7:0] val, input logic rdy,
                        input logic track_order = 1'b0);
        logic ev;
        logic rise;
        @(negedge clk);
        check_outputs(rdy, track_order);
        reset       = 1'b1;
        sum_valid   = v;
        sum_in      = val;
        event_ready = rdy;
        if (exp_q.size() != 0 && rdy) begin
            void'(exp_q.pop_front());
        end
        if (v) begin
            ev   = 1'b0;
            rise = 1'b0;
            if (m_warm > 0) begin
                m_warm--;
            end else if (m_init) begin
                m_init  = 1'b0;
                m_alarm = (val >= threshold_hi);
            end else if (!m_alarm && val >= threshold_hi) begin
                m_alarm = 1'b1;
                ev      = 1'b1;
                rise    = 1'b1;
            end else if (m_alarm && val <= threshold_lo) begin
                m_alarm = 1'b0;
                ev      = 1'b1;
            end
            if (ev) begin
                if (exp_q.size() < DEPTH) exp_q.push_back({rise, val, m_stamp});
                else m_ovf = 1'b1;
            end
            m_stamp++;
        end
        @(posedge clk);
    endtask

    initial begin
        model_reset();
        dut_pops      = 0;
        have_last_pop = 1'b0;

        // warm-up, INIT, first rise
        do_reset();
        threshold_hi = 8'd100;
        threshold_lo = 8'd50;
        for (int i = 0; i < 3; i++) step(1'b1, 8'd200, 1'b0);
        step(1'b1, 8'd10, 1'b0);
        step(1'b0, 8'd0, 1'b0);
        step(1'b1, 8'd120, 1'b0);
        step(1'b0, 8'd0, 1'b0);
        chk("rise_head_value", 32'(event_value), 32'd120);
        chk("rise_head_stamp", 32'(event_stamp), 32'd4);

        // hysteresis in ALARM: 80, 60 hold; 50 clears; 99 stays quiet
        step(1'b1, 8'd80, 1'b1);
        step(1'b1, 8'd60, 1'b1);
        step(1'b1, 8'd50, 1'b1);
        step(1'b1, 8'd99, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 8'd0, 1'b1);

        // overflow: ready low, 6 alternating post-INIT samples
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 8'd0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, (i % 2 == 0) ? 8'd150 : 8'd0, 1'b0);
        step(1'b0, 8'd0, 1'b0);
        chk("overflow_set", 32'(overflow), 32'd1);
        chk("alarm_after_ovf", 32'(in_alarm), 32'd0);

        // full FIFO with simultaneous push and pop, then drain
        step(1'b1, 8'd150, 1'b1);
        dut_pops      = 0;
        have_last_pop = 1'b0;
        for (int i = 0; i < 6; i++) step(1'b0, 8'd0, 1'b1, 1'b1);
        chk("drain_count", 32'(dut_pops), 32'd4);

        // idle gaps between samples, equality at hi, and lo >= hi
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'd100, 1'b1);
            step(1'b0, 8'd0, 1'b1);
            step(1'b0, 8'd0, 1'b1);
            step(1'b1, 8'd50, 1'b1);
            step(1'b0, 8'd0, 1'b1);
        end
        threshold_hi = 8'd50;
        threshold_lo = 8'd100;
        step(1'b1, 8'd70, 1'b1);
        step(1'b1, 8'd70, 1'b1);
        step(1'b1, 8'd30, 1'b1);
        step(1'b0, 8'd0, 1'b1);
        threshold_hi = 8'd100;
        threshold_lo = 8'd50;
        step(1'b0, 8'd0, 1'b1);

        // stamp wrap: index 65535 raises, the following index 0 clears
        do_reset();
        for (int i = 0; i < 65535; i++) step(1'b1, 8'd0, 1'b1);
        step(1'b1, 8'd200, 1'b0);
        step(1'b1, 8'd0, 1'b0);
        step(1'b0, 8'd0, 1'b0);
        chk("wrap_head_stamp", 32'(event_stamp), 32'd65535);
        step(1'b0, 8'd0, 1'b1);
        step(1'b0, 8'd0, 1'b0);
        chk("wrapped_stamp", 32'(event_stamp), 32'd0);
        for (int i = 0; i < 2; i++) step(1'b0, 8'd0, 1'b1);

        // reset with 2 queued events and alarm set
        step(1'b1, 8'd200, 1'b0);
        step(1'b1, 8'd0, 1'b0);
        step(1'b1, 8'd200, 1'b0);
        step(1'b0, 8'd0, 1'b1);
        step(1'b0, 8'd0, 1'b0);
        chk("pre_reset_alarm", 32'(in_alarm), 32'd1);
        do_reset();
        step(1'b0, 8'd0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'd255, 1'b0);
        step(1'b1, 8'd255, 1'b0);
        step(1'b0, 8'd0, 1'b0);
        chk("post_warmup_quiet", 32'(event_valid), 32'd0);
        chk("post_init_alarm", 32'(in_alarm), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
